// File: rtl/lpe_pkg.sv
// -----------------------------------------------------------------------------
// lpe_pkg
//
// Shared definitions for the Laconic processing element shift-accumulate path.
//
// Contents:
//   CNT_W, SHIFT_W, ACC_W, BEAT_W  default widths for the accumulator stage
//   state_t                        accumulator FSM encoding (2'd3 is illegal)
//   min_acc_w()                    smallest accumulator width that holds one
//                                  term without losing bits
// -----------------------------------------------------------------------------
package lpe_pkg;

    // Default widths. A 16-input parallel counter produces a 0..16 count (5 bits).
    localparam int CNT_W   = 5;
    localparam int SHIFT_W = 4;
    localparam int ACC_W   = 24;
    localparam int BEAT_W  = 8;

    // Accumulator FSM encoding. The unused code 2'd3 recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to hold the largest single term:
    // a full-scale count shifted by the largest exponent.
    function automatic int min_acc_w(input int cnt_w, input int shift_w);
        return cnt_w + (2 ** shift_w) - 1;
    endfunction

endpackage : lpe_pkg

// File: rtl/lpe_term_shifter.sv
// -----------------------------------------------------------------------------
// lpe_term_shifter
//
// Combinational weighting of one exponent bucket: term = cnt << shift.
// The result is ACC_W+1 bits wide so the accumulator adder can see the
// carry-out of a full-width sum when the term is added to ACC_W bits of state.
// Shared by the single-lane accumulator and the multi-lane PE variants.
//
// Parameters:
//   CNT_W    width of the parallel-counter count
//   SHIFT_W  width of the bucket exponent
//   ACC_W    accumulator width (term is ACC_W+1 bits)
//
// Ports:
//   cnt    in   CNT_W    count of term-pairs that hit this bucket
//   shift  in   SHIFT_W  exponent of this bucket
//   term   out  ACC_W+1  zero-extended cnt shifted left by shift
// -----------------------------------------------------------------------------
module lpe_term_shifter
    import lpe_pkg::*;
#(
    parameter int CNT_W   = lpe_pkg::CNT_W,
    parameter int SHIFT_W = lpe_pkg::SHIFT_W,
    parameter int ACC_W   = lpe_pkg::ACC_W
) (
    input  logic [CNT_W-1:0]   cnt,
    input  logic [SHIFT_W-1:0] shift,
    output logic [ACC_W:0]     term
);

    // A narrower accumulator would silently drop high bits of a single term,
    // so refuse to elaborate rather than produce wrong sums.
    if (ACC_W < min_acc_w(CNT_W, SHIFT_W)) begin : g_width_check
        $error("lpe_term_shifter: ACC_W too small for CNT_W/SHIFT_W");
    end

    logic [ACC_W:0] cnt_ext;

    // Zero-extend before shifting so no count bit falls off the top.
    assign cnt_ext = {{(ACC_W + 1 - CNT_W){1'b0}}, cnt};
    assign term    = cnt_ext << shift;

endmodule : lpe_term_shifter

// File: rtl/lpe_shift_accumulator.sv
// -----------------------------------------------------------------------------
// lpe_shift_accumulator
//
// Downstream stage of the 16-input / 5-bit parallel counter in the Laconic PE.
// Each beat carries one bucket count and that bucket's exponent; the block
// sums count << exponent over a packet (terminated by in_last) and offers the
// partial dot-product through a valid/ready handshake.
//
// FSM: IDLE -> (first beat) -> ACCUM -> (last beat) -> DONE -> (out_ready) -> IDLE
//      A single-beat packet goes straight from IDLE to DONE.
//      While DONE, no beats are accepted (in_ready = 0).
//
// Configuration macro:
//   LPE_ACC_SAT_EN  defined   : on carry-out the accumulator clamps to all ones
//                               and stays clamped for the rest of the packet.
//                   undefined : the accumulator wraps modulo 2^ACC_W.
//                   In both builds out_ovf is sticky for the packet.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous active-low reset
//   in_valid    in   1        upstream beat valid
//   in_ready    out  1        block can accept a beat (IDLE or ACCUM)
//   in_cnt      in   CNT_W    parallel-counter count for this bucket
//   in_shift    in   SHIFT_W  exponent of this bucket
//   in_last     in   1        final beat of the packet
//   out_valid   out  1        result available (DONE)
//   out_ready   in   1        downstream accepts the result
//   out_result  out  ACC_W    accumulated sum
//   out_beats   out  BEAT_W   beats in packet, saturating at 2^BEAT_W-1
//   out_ovf     out  1        accumulator overflowed during the packet
// -----------------------------------------------------------------------------
module lpe_shift_accumulator
    import lpe_pkg::*;
#(
    parameter int CNT_W   = lpe_pkg::CNT_W,
    parameter int SHIFT_W = lpe_pkg::SHIFT_W,
    parameter int ACC_W   = lpe_pkg::ACC_W,
    parameter int BEAT_W  = lpe_pkg::BEAT_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CNT_W-1:0]   in_cnt,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_last,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_result,
    output logic [BEAT_W-1:0]  out_beats,
    output logic               out_ovf
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;

    logic [ACC_W-1:0]    acc_q;
    logic [BEAT_W-1:0]   beats_q;
    logic                ovf_q;

    logic [ACC_W:0]      term;
    logic [ACC_W:0]      sum;
    logic                carry;
    logic [ACC_W-1:0]    acc_next;
    logic [BEAT_W-1:0]   beats_next;
    logic                accept;

    // -------------------------------------------------------------------------
    // Term generation and accumulate arithmetic
    // -------------------------------------------------------------------------
    lpe_term_shifter #(
        .CNT_W   (CNT_W),
        .SHIFT_W (SHIFT_W),
        .ACC_W   (ACC_W)
    ) u_term_shifter (
        .cnt   (in_cnt),
        .shift (in_shift),
        .term  (term)
    );

    assign accept = in_valid && in_ready;

    // One extra bit on the adder exposes the carry-out of the ACC_W-bit sum.
    assign sum   = {1'b0, acc_q} + term;
    assign carry = sum[ACC_W];

`ifdef LPE_ACC_SAT_EN
    // Once the packet has overflowed the sum is meaningless, so hold the clamp
    // even if later beats would not carry on their own.
    assign acc_next = (ovf_q || carry) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    // Plain modulo-2^ACC_W wrap; overflow is only reported through out_ovf.
    assign acc_next = sum[ACC_W-1:0];
`endif

    // Beat count sticks at all ones instead of wrapping on very long packets.
    assign beats_next = (beats_q == {BEAT_W{1'b1}}) ? beats_q : beats_q + 1'b1;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering in simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so every path assigns it;
    // without that, synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;    // 2'd3 is unreachable; recover
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator, beat counter and overflow flag
    // -------------------------------------------------------------------------
    // These registers double as the result holding registers: once in DONE
    // nothing can write them until the result is taken, so they stay stable
    // for the whole backpressure period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        // First beat starts a fresh packet, whatever was left.
                        acc_q   <= term[ACC_W-1:0];
                        beats_q <= {{(BEAT_W-1){1'b0}}, 1'b1};
                        ovf_q   <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_next;
                        beats_q <= beats_next;
                        ovf_q   <= ovf_q | carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        beats_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    acc_q   <= '0;
                    beats_q <= '0;
                    ovf_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_result = acc_q;
    assign out_beats  = beats_q;
    assign out_ovf    = ovf_q;

endmodule : lpe_shift_accumulator

// File: tb/tb_lpe_shift_accumulator.sv
// -----------------------------------------------------------------------------
// tb_lpe_shift_accumulator
//
// Directed self-checking bench for lpe_shift_accumulator at default widths.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Build with +define+LPE_ACC_SAT_EN to check the saturating variant.
// -----------------------------------------------------------------------------
module tb_lpe_shift_accumulator;

    localparam int CNT_W   = lpe_pkg::CNT_W;
    localparam int SHIFT_W = lpe_pkg::SHIFT_W;
    localparam int ACC_W   = lpe_pkg::ACC_W;
    localparam int BEAT_W  = lpe_pkg::BEAT_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [CNT_W-1:0]   in_cnt;
    logic [SHIFT_W-1:0] in_shift;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_result;
    logic [BEAT_W-1:0]  out_beats;
    logic               out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    lpe_shift_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cnt     (in_cnt),
        .in_shift   (in_shift),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_beats  (out_beats),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge.
    task automatic beat(input logic [CNT_W-1:0] c, input logic [SHIFT_W-1:0] s, input logic l);
        in_valid = 1'b1;
        in_cnt   = c;
        in_shift = s;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Take the pending result with a one-edge out_ready pulse.
    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cnt    = '0;
        in_shift  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_result !== 24'd0) begin n_err++; $display("FAIL reset_result: got %0d want 0", out_result); end
        n_cmp++; if (out_beats !== 8'd0) begin n_err++; $display("FAIL reset_beats: got %0d want 0", out_beats); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        rst_n = 1'b1;
        tick();
    endtask

    // 5 << 3 = 40, visible right after the accepting edge.
    task automatic test_single_beat();
        beat(5'd5, 4'd3, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 24'd40) begin n_err++; $display("FAIL single_result: got %0d want 40", out_result); end
        n_cmp++; if (out_beats !== 8'd1) begin n_err++; $display("FAIL single_beats: got %0d want 1", out_beats); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", out_ovf); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_in_ready: got %b want 0", in_ready); end
        drain();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drop: got %b want 0", out_valid); end
    endtask

    // 16 + 32768 + 112 = 32896; with out_ready held high DONE lasts one cycle.
    task automatic test_back_to_back();
        int lows;
        out_ready = 1'b1;
        beat(5'd16, 4'd0, 1'b0);
        beat(5'd1, 4'd15, 1'b0);
        beat(5'd7, 4'd4, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 24'd32896) begin n_err++; $display("FAIL b2b_result: got %0d want 32896", out_result); end
        n_cmp++; if (out_beats !== 8'd3) begin n_err++; $display("FAIL b2b_beats: got %0d want 3", out_beats); end
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b1) lows++;
            tick();
        end
        n_cmp++; if (lows != 1) begin n_err++; $display("FAIL b2b_ready_low_cycles: got %0d want 1", lows); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    // Result 9<<2 = 36 held under backpressure while a 3<<1 beat waits.
    task automatic test_backpressure();
        beat(5'd9, 4'd2, 1'b1);
        in_valid = 1'b1;
        in_cnt   = 5'd3;
        in_shift = 4'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (out_result !== 24'd36) begin n_err++; $display("FAIL bp_result[%0d]: got %0d want 36", i, out_result); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 24'd6) begin n_err++; $display("FAIL bp_next_result: got %0d want 6", out_result); end
        n_cmp++; if (out_beats !== 8'd1) begin n_err++; $display("FAIL bp_next_beats: got %0d want 1", out_beats); end
        drain();
    endtask

    // 32 * (16 << 15) = 2^24: carries out on the final beat.
    task automatic test_overflow();
        logic [ACC_W-1:0] exp_res;
`ifdef LPE_ACC_SAT_EN
        exp_res = 24'hFFFFFF;
`else
        exp_res = 24'h000000;
`endif
        for (int i = 0; i < 32; i++) begin
            beat(5'd16, 4'd15, (i == 31));
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== exp_res) begin n_err++; $display("FAIL ovf_result: got %h want %h", out_result, exp_res); end
        n_cmp++; if (out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", out_ovf); end
        n_cmp++; if (out_beats !== 8'd32) begin n_err++; $display("FAIL ovf_beats: got %0d want 32", out_beats); end
        drain();
    endtask

    // Reset after two (3,2) beats discards them; next packet 2<<1 = 4.
    task automatic test_reset_mid_packet();
        beat(5'd3, 4'd2, 1'b0);
        beat(5'd3, 4'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_result !== 24'd0) begin n_err++; $display("FAIL midrst_result: got %0d want 0", out_result); end
        n_cmp++; if (out_beats !== 8'd0) begin n_err++; $display("FAIL midrst_beats: got %0d want 0", out_beats); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", out_ovf); end
        beat(5'd2, 4'd1, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_next_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 24'd4) begin n_err++; $display("FAIL midrst_next_result: got %0d want 4", out_result); end
        n_cmp++; if (out_beats !== 8'd1) begin n_err++; $display("FAIL midrst_next_beats: got %0d want 1", out_beats); end
        drain();
    endtask

    // All-zero counts; also shows out_ovf does not leak from an earlier packet.
    task automatic test_zero_packet();
        beat(5'd0, 4'd7, 1'b0);
        beat(5'd0, 4'd0, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 24'd0) begin n_err++; $display("FAIL zero_result: got %0d want 0", out_result); end
        n_cmp++; if (out_beats !== 8'd2) begin n_err++; $display("FAIL zero_beats: got %0d want 2", out_beats); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL zero_ovf: got %b want 0", out_ovf); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_zero_packet();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lpe_shift_accumulator
